// File: rtl/pc_register.sv
// Program-counter register for the multi-cycle datapath: two-phase ISSUE/UPDATE commit,
// branch buffering, misaligned-target trap. Optional macro PC_CONSISTENCY_CHECK_EN.
module pc_register #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inPCAdder,
  input  logic [31:0] branchTarget,
  input  logic        branchTaken,
  input  logic        stall,
  output logic [31:0] PC,
  output logic        pcValid,
  output logic        trap,
  output logic        adderError,
  output logic [31:0] commitCount
);

  typedef enum logic [1:0] {START, ISSUE, UPDATE, TRAP} state_t;

  state_t      state;
  logic        pending;
  logic [31:0] pendingTarget;
  logic [31:0] nextPc;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

`ifdef PC_CONSISTENCY_CHECK_EN
  logic [31:0] pcPlus4;
  logic        adderMismatch;
  logic        adderErrorR;

  assign pcPlus4    = PC + 32'd4;
  assign adderError = adderErrorR;
`else
  assign adderError = 1'b0;
`endif

  // Live redirect beats a buffered one, which beats the sequential path.
  always_comb begin
    nextPc = inPCAdder;
`ifdef PC_CONSISTENCY_CHECK_EN
    adderMismatch = 1'b0;
`endif
    if (branchTaken) begin
      nextPc = branchTarget;
    end else if (pending) begin
      nextPc = pendingTarget;
    end else begin
`ifdef PC_CONSISTENCY_CHECK_EN
      if (inPCAdder != pcPlus4) begin
        adderMismatch = 1'b1;
        nextPc        = pcPlus4;
      end
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= START;
      PC            <= RESET_VECTOR;
      pcValid       <= 1'b0;
      pending       <= 1'b0;
      pendingTarget <= 32'h0;
      trap          <= 1'b0;
      commitCount   <= 32'h0;
`ifdef PC_CONSISTENCY_CHECK_EN
      adderErrorR   <= 1'b0;
`endif
    end else begin
      case (state)
        START: begin
          if (branchTaken) begin
            pending       <= 1'b1;
            pendingTarget <= branchTarget;
          end
          state   <= ISSUE;
          pcValid <= 1'b1;
        end
        ISSUE: begin
          if (branchTaken) begin
            pending       <= 1'b1;
            pendingTarget <= branchTarget;
          end
          if (!stall) begin
            state   <= UPDATE;
            pcValid <= 1'b0;
          end
        end
        UPDATE: begin
`ifdef PC_CONSISTENCY_CHECK_EN
          if (adderMismatch) adderErrorR <= 1'b1;
`endif
          if (misaligned(nextPc)) begin
            trap    <= 1'b1;
            state   <= TRAP;
            pcValid <= 1'b0;
          end else begin
            PC          <= nextPc;
            commitCount <= commitCount + 32'd1;
            pending     <= 1'b0;
            state       <= ISSUE;
            pcValid     <= 1'b1;
          end
        end
        default: begin
          // TRAP: frozen until reset.
          state   <= TRAP;
          pcValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_register.sv
// Directed bench for pc_register: per-cycle comparison against a behavioural model
// plus literal spot checks of the model-independent expectations.
module tb_pc_register;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inPCAdder;
  logic [31:0] branchTarget;
  logic        branchTaken;
  logic        stall;
  logic [31:0] PC;
  logic        pcValid;
  logic        trap;
  logic        adderError;
  logic [31:0] commitCount;

  int total = 0;
  int bad   = 0;

  logic [31:0] adder_reg = 32'h0;
  logic        force_adder = 1'b0;
  logic [31:0] force_val = 32'h0;
  logic        chk_en = 1'b0;

  pc_register #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .inPCAdder    (inPCAdder),
    .branchTarget (branchTarget),
    .branchTaken  (branchTaken),
    .stall        (stall),
    .PC           (PC),
    .pcValid      (pcValid),
    .trap         (trap),
    .adderError   (adderError),
    .commitCount  (commitCount)
  );

  always #5 clock = ~clock;

  // Environment adder: registers PC+4 every clock.
  always @(posedge clock) adder_reg <= PC + 32'd4;
  assign inPCAdder = force_adder ? force_val : adder_reg;

  // Behavioural model. m_phase: 0 = just out of reset, 1 = PC offered, 2 = choosing next PC.
  int          m_phase = 0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic        m_trap = 1'b0;
  logic        m_err = 1'b0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;
  logic [31:0] m_next;
  logic [31:0] m_seq;

  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_pc = 32'h0; m_cnt = 32'h0; m_trap = 1'b0;
      m_err = 1'b0; m_pend = 1'b0; m_ptgt = 32'h0;
    end else if (!m_trap) begin
      if (m_phase == 2) begin
        m_seq = force_adder ? force_val : m_pc + 32'd4;
`ifdef PC_CONSISTENCY_CHECK_EN
        if (!branchTaken && !m_pend && m_seq != m_pc + 32'd4) begin
          m_err = 1'b1;
          m_seq = m_pc + 32'd4;
        end
`endif
        m_next = branchTaken ? branchTarget : (m_pend ? m_ptgt : m_seq);
        if (m_next % 4 != 0) begin
          m_trap = 1'b1;
        end else begin
          m_pc   = m_next;
          m_cnt  = m_cnt + 1;
          m_pend = 1'b0;
          m_phase = 1;
        end
      end else begin
        if (branchTaken) begin
          m_pend = 1'b1;
          m_ptgt = branchTarget;
        end
        if (m_phase == 0 || !stall) m_phase = m_phase + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_pc", PC, m_pc);
      check("cyc_valid", {31'h0, pcValid}, {31'h0, (m_phase == 1) && !m_trap});
      check("cyc_trap", {31'h0, trap}, {31'h0, m_trap});
      check("cyc_count", commitCount, m_cnt);
      check("cyc_adderr", {31'h0, adderError}, {31'h0, m_err});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    branchTaken = 1'b0;
    stall = 1'b0;
    force_adder = 1'b0;
    tick(2);
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; branchTarget = 32'h0; branchTaken = 1'b0; stall = 1'b0;

    // Sequential fetch 0,4,8,12.
    do_reset();
    check("rst_pc", PC, 32'h0);
    check("rst_valid", {31'h0, pcValid}, 32'h0);
    check("rst_count", commitCount, 32'h0);
    check("rst_trap", {31'h0, trap}, 32'h0);
    tick(1);
    check("issue_valid", {31'h0, pcValid}, 32'h1);
    tick(2);
    check("first_commit", PC, 32'h4);
    tick(4);
    check("seq_pc", PC, 32'hC);
    check("seq_count", commitCount, 32'h3);

    // Branch in ISSUE at PC=8.
    do_reset();
    tick(5);
    check("at_pc8", PC, 32'h8);
    branchTaken = 1'b1; branchTarget = 32'h100;
    tick(1);
    branchTaken = 1'b0;
    tick(1);
    check("branch_pc", PC, 32'h100);
    tick(2);
    check("after_branch", PC, 32'h104);

    // Latest buffered request wins.
    do_reset();
    branchTaken = 1'b1; branchTarget = 32'h200;
    tick(1);
    branchTarget = 32'h300;
    tick(1);
    branchTaken = 1'b0;
    tick(1);
    check("latest_wins", PC, 32'h300);

    // Stall three cycles at PC=4; stall ignored in UPDATE.
    do_reset();
    tick(3);
    stall = 1'b1;
    tick(3);
    check("stall_valid", {31'h0, pcValid}, 32'h1);
    check("stall_pc", PC, 32'h4);
    stall = 1'b0;
    tick(1);
    stall = 1'b1;
    tick(1);
    check("stall_commit", PC, 32'h8);
    stall = 1'b0;
    tick(2);
    check("stall_resume", PC, 32'hC);

    // Live branch beats pending in UPDATE.
    do_reset();
    branchTaken = 1'b1; branchTarget = 32'h200;
    tick(1);
    branchTaken = 1'b0;
    tick(1);
    branchTaken = 1'b1; branchTarget = 32'h400;
    tick(1);
    branchTaken = 1'b0;
    check("live_wins", PC, 32'h400);
    tick(2);
    check("pend_cleared", PC, 32'h404);

    // Address wrap.
    do_reset();
    branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
    tick(1);
    branchTaken = 1'b0;
    tick(2);
    check("top_pc", PC, 32'hFFFF_FFFC);
    tick(2);
    check("wrap_pc", PC, 32'h0);

    // Reset in UPDATE: no commit.
    do_reset();
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midupd_pc", PC, 32'h0);
    check("midupd_count", commitCount, 32'h0);
    reset = 1'b0;
    tick(3);

    // Misaligned target traps.
    do_reset();
    tick(4);
    branchTaken = 1'b1; branchTarget = 32'h102;
    tick(1);
    check("trap_flag", {31'h0, trap}, 32'h1);
    check("trap_pc", PC, 32'h4);
    check("trap_count", commitCount, 32'h1);
    branchTarget = 32'h200;
    tick(3);
    check("trap_hold_pc", PC, 32'h4);
    check("trap_valid", {31'h0, pcValid}, 32'h0);
    do_reset();
    check("trap_clr", {31'h0, trap}, 32'h0);
    check("trap_rst_pc", PC, 32'h0);

    // Corrupted adder result at PC=8.
    do_reset();
    tick(6);
    force_adder = 1'b1; force_val = 32'h0000_DEAD;
    tick(1);
    force_adder = 1'b0;
`ifdef PC_CONSISTENCY_CHECK_EN
    check("adder_err", {31'h0, adderError}, 32'h1);
    check("adder_pc", PC, 32'hC);
`else
    check("adder_trap", {31'h0, trap}, 32'h1);
    check("adder_pc", PC, 32'h8);
    check("adder_err0", {31'h0, adderError}, 32'h0);
`endif
    tick(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
